// File: rtl/resp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : resp_pkg
// Brief   : Shared response-path constants and byte type (dispatcher, FIFO, UART).
// Rev     : 1.0  initial release
// ============================================================================
package resp_pkg;

  localparam int RESP_DATA_W     = 8;
  localparam int RESP_FIFO_DEPTH = 16;

  typedef logic [RESP_DATA_W-1:0] resp_byte_t;

endpackage : resp_pkg
`default_nettype wire

// File: rtl/resp_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : resp_fifo_mem
// Brief   : DEPTH x DATA_W storage, synchronous write, asynchronous read.
// Rev     : 1.0  initial release
// ============================================================================
module resp_fifo_mem
  import resp_pkg::*;
#(
  parameter int DATA_W = RESP_DATA_W,
  parameter int DEPTH  = RESP_FIFO_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset on the array so it can map onto distributed RAM.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : resp_fifo_mem
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : resp_fifo
// Brief   : First-word-fall-through response byte FIFO, cmd_dispatcher -> uart_tx.
//           Optional high-watermark tracking under RESP_FIFO_WATERMARK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module resp_fifo
  import resp_pkg::*;
#(
  parameter int DATA_W       = RESP_DATA_W,
  parameter int DEPTH        = RESP_FIFO_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   afull
`ifdef RESP_FIFO_WATERMARK_EN
  ,
  output logic [$clog2(DEPTH):0] max_level,
  input  logic                   wm_clr
`endif
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            PW        = AW + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_fire;
  logic          rd_fire;

  // Status is decoded only from registered pointers, so handshake outputs
  // never see the incoming valid/ready combinationally.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign afull    = (level >= AFULL_LVL);
  assign wr_ready = !full;
  assign rd_valid = !empty;

  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  resp_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef RESP_FIFO_WATERMARK_EN
  logic [PW-1:0] max_level_q, max_level_d;

  // A clear reloads from the live level rather than zero.
  always_comb begin
    max_level_d = max_level_q;
    if (wm_clr) begin
      max_level_d = level;
    end else if (level > max_level_q) begin
      max_level_d = level;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_level_q <= '0;
    end else begin
      max_level_q <= max_level_d;
    end
  end

  assign max_level = max_level_q;
`endif

endmodule : resp_fifo
`default_nettype wire

// File: tb/tb_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_resp_fifo
// Brief   : Self-checking bench for resp_fifo against a queue reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_resp_fifo;

  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [PW-1:0] level;
  logic          full;
  logic          empty;
  logic          afull;
  logic [PW-1:0] max_level;
  logic          wm_clr;

  resp_fifo #(
    .DATA_W       (8),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (DEPTH - 2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .afull     (afull)
`ifdef RESP_FIFO_WATERMARK_EN
    ,
    .max_level (max_level),
    .wm_clr    (wm_clr)
`endif
  );

`ifndef RESP_FIFO_WATERMARK_EN
  assign max_level = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain byte queue plus the high-watermark value.
  logic [7:0] q[$];
  int         mx;
  int         n_checks;
  int         n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    chk({tag, ".level"},    32'(level),    32'(n));
    chk({tag, ".empty"},    32'(empty),    32'(n == 0));
    chk({tag, ".full"},     32'(full),     32'(n == DEPTH));
    chk({tag, ".afull"},    32'(afull),    32'(n >= DEPTH - 2));
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(n < DEPTH));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(n > 0));
    if (n > 0) begin
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
    end
`ifdef RESP_FIFO_WATERMARK_EN
    chk({tag, ".max_level"}, 32'(max_level), 32'(mx));
`endif
  endtask

  // One clock: decide handshakes from model occupancy, update model at the edge.
  task automatic step();
    bit wf, rf;
    int pre;
    pre = q.size();
    wf  = wr_valid && (pre < DEPTH);
    rf  = rd_ready && (pre > 0);
    @(posedge clk);
    if (rf) void'(q.pop_front());
    if (wf) q.push_back(wr_data);
    if (wm_clr) mx = pre;
    else if (pre > mx) mx = pre;
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    rd_ready = 1'b0;
    step();
    wr_valid = 1'b0;
  endtask

  logic [7:0] ins[$];
  logic [7:0] outs[$];
  int         sent;
  int         cyc;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mx       = 0;
    rst      = 1'b1;
    wr_data  = '0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wm_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("reset");

    // Single byte round trip
    push(8'hA5);
    check_state("single_wr");
    chk("single_rd_data", 32'(rd_data), 32'hA5);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check_state("single_rd");

    // Fill to full; afull tracked each step
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i));
      check_state("fill");
    end
    chk("fill_full", 32'(full), 32'd1);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    step();
    wr_valid = 1'b0;
    check_state("overflow");
    chk("overflow_level", 32'(level), 32'd16);

    // Write+read while full: read only, write lands next cycle
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    rd_ready = 1'b1;
    step();
    check_state("full_rw");
    chk("full_rw_level", 32'(level), 32'd15);
    rd_ready = 1'b0;
    step();
    wr_valid = 1'b0;
    check_state("full_rw_next");
    chk("full_rw_next_level", 32'(level), 32'd16);
    rd_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_order", 32'(rd_data), (i < DEPTH) ? 32'(i) : 32'h55);
      step();
      check_state("drain");
    end
    rd_ready = 1'b0;

    // Random-ready stream across pointer wrap
    sent = 0;
    ins.delete();
    outs.delete();
    for (cyc = 0; cyc < 400 && (sent < 40 || q.size() > 0); cyc++) begin
      wr_valid = (sent < 40);
      wr_data  = 8'($urandom);
      rd_ready = 1'($urandom_range(0, 1));
      if (wr_valid && q.size() < DEPTH) begin
        ins.push_back(wr_data);
        sent++;
      end
      if (rd_ready && rd_valid) outs.push_back(rd_data);
      step();
      check_state("stream");
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("stream_done", 32'(cyc < 400), 32'd1);
    chk("stream_count", 32'(outs.size()), 32'(ins.size()));
    for (int i = 0; i < ins.size() && i < outs.size(); i++) begin
      chk("stream_order", 32'(outs[i]), 32'(ins[i]));
    end

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 7; i++) push(8'(8'h10 + i));
    check_state("pre_rst");
    rd_ready = 1'b1;
    #2;
    rst = 1'b1;
    q.delete();
    mx = 0;
    #1;
    check_state("async_rst");
    rd_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(8'h3C);
    check_state("post_rst");
    chk("post_rst_data", 32'(rd_data), 32'h3C);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check_state("post_rst_rd");

`ifdef RESP_FIFO_WATERMARK_EN
    for (int i = 0; i < 9; i++) push(8'(i));
    rd_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    rd_ready = 1'b0;
    step();
    check_state("wm_peak");
    chk("wm_peak_val", 32'(max_level), 32'd9);
    wm_clr = 1'b1;
    step();
    wm_clr = 1'b0;
    check_state("wm_clr");
    chk("wm_clr_val", 32'(max_level), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_resp_fifo
`default_nettype wire
